// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the CPU-to-SDRAM adapter and the cache fill path:
//   - RISC-V funct3 load/store size codes
//   - adapter FSM state encoding
//   - size_bytes(size)         : access width in bytes
//   - is_aligned(addr_lo, size): natural-alignment test on the low address bits
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // The low two bits of funct3 encode log2(bytes); bit 2 only selects
    // zero-extension, so signed and unsigned variants share a width.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
        logic [3:0] w_mask;
        w_mask = size_bytes(size) - 4'd1;
        return (addr_lo & w_mask[2:0]) == 3'b000;
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational load-result formatter: takes the assembled little-endian
// beats, drops the leading byte lanes, and sign- or zero-extends the field
// selected by the funct3 size code. Shared with the cache fill path.
// Ports:
//   i_beats  [XLEN-1:0] assembled read data, beat 0 in the low bits
//   i_off    [2:0]      byte offset of the field inside i_beats
//   i_size   [2:0]      funct3 size code (bit 2 = zero-extend)
//   o_result [XLEN-1:0] extended load result
// -----------------------------------------------------------------------------
module load_extract
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_beats,
    input  logic [2:0]      i_off,
    input  logic [2:0]      i_size,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_shifted;
    logic            w_fill;
    int              w_nbits;

    always_comb begin
        w_shifted = i_beats >> {i_off, 3'b000};
        w_nbits   = 8 * int'(size_bytes(i_size));
        if (w_nbits > XLEN) begin
            w_nbits = XLEN;
        end
        // Loop with constant indices picks the field's top bit.
        w_fill = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == w_nbits - 1) begin
                w_fill = w_shifted[i] & ~i_size[2];
            end
        end
        o_result = w_shifted;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= w_nbits) begin
                o_result[i] = w_fill;
            end
        end
    end

endmodule

// File: rtl/sdram_mem_adapter.sv
// -----------------------------------------------------------------------------
// sdram_mem_adapter
// Turns one CPU load/store (byte/half/word/dword) into 1..BEATS beats of an
// SDRAM controller of width MEM_W. Stores drive per-beat DQM masks, loads are
// assembled and extended. Misaligned/illegal accesses complete with acc_err
// without any controller command.
// Ports:
//   clk, reset (async, active-low)
//   CPU side : rd_req, wr_req (levels), mem_addr, mem_size, indata,
//              outdata, rd_valid, wr_valid, acc_err (one-cycle pulses)
//   Ctl side : ctl_init, ctl_idle, ctl_addr, ctl_burst, ctl_rd_req,
//              ctl_wr_req, ctl_wr_data, ctl_dqm, ctl_wr_ack, ctl_rd_data,
//              ctl_rd_data_valid
//   Debug    : o_dbg_state (current FSM state)
//
// Handshakes: a CPU request is a level held until its valid pulse; it is
// taken in IDLE when ctl_init=1. A controller command is a single-cycle pulse
// issued in ISSUE while ctl_idle=1. Write beat k is presented until the cycle
// ctl_wr_ack=1 consumes it; read beats are accepted on ctl_rd_data_valid.
// Acks/valids outside the matching data state are ignored.
// -----------------------------------------------------------------------------
module sdram_mem_adapter
    import mem_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int MEM_W   = 16,
    parameter  int ADDR_W  = 32,
    localparam int BEATS   = XLEN / MEM_W,
    localparam int BURST_W = $clog2(BEATS) + 1,
    localparam int LANE_B  = MEM_W / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [2:0]          mem_size,
    input  logic [XLEN-1:0]     indata,
    output logic [XLEN-1:0]     outdata,
    output logic                rd_valid,
    output logic                wr_valid,
    output logic                acc_err,
    input  logic                ctl_init,
    input  logic                ctl_idle,
    output logic [ADDR_W-1:0]   ctl_addr,
    output logic [BURST_W-1:0]  ctl_burst,
    output logic                ctl_rd_req,
    output logic                ctl_wr_req,
    output logic [MEM_W-1:0]    ctl_wr_data,
    output logic [LANE_B-1:0]   ctl_dqm,
    input  logic                ctl_wr_ack,
    input  logic [MEM_W-1:0]    ctl_rd_data,
    input  logic                ctl_rd_data_valid,
    output state_t              o_dbg_state
);

    localparam int LANE_SH = $clog2(LANE_B);

    state_t               r_state, w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [2:0]           r_size;
    logic [XLEN-1:0]      r_data;
    logic                 r_is_wr;
    logic                 r_err;
    logic [BURST_W-1:0]   r_nbeats;
    logic [BURST_W-1:0]   r_beat;
    logic [2:0]           r_off;
    logic [XLEN/8-1:0]    r_byte_en;
    logic [XLEN-1:0]      r_beats;
    logic [XLEN-1:0]      r_outdata;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_err;
    logic                 w_last;
    logic                 w_busy;
    logic [3:0]           w_sb;
    logic [2:0]           w_off;
    logic [BURST_W-1:0]   w_nbeats;
    logic [XLEN-1:0]      w_mask_data;
    logic [XLEN-1:0]      w_wdata;
    logic [XLEN/8-1:0]    w_en;
    logic [XLEN/8-1:0]    w_byte_en;
    logic [XLEN-1:0]      w_assembled;
    logic [XLEN-1:0]      w_ext;
    logic [MEM_W-1:0]     w_beat_data;
    logic [LANE_B-1:0]    w_beat_en;

    assign w_accept = ctl_init && (rd_req || wr_req);
    assign w_last   = (r_beat == r_nbeats - BURST_W'(1));

    // Access decode, evaluated while in CHECK from the latched request.
    always_comb begin
        w_sb     = size_bytes(r_size);
        w_off    = r_addr[2:0] & 3'(LANE_B - 1);
        w_legal  = (r_size != 3'b111) &&
                   ((XLEN == 64) || ((r_size != SZ_D) && (r_size != SZ_WU)));
        w_err    = !w_legal || !is_aligned(r_addr[2:0], r_size);
        w_nbeats = (int'(w_sb) >= LANE_B) ? BURST_W'(int'(w_sb) / LANE_B) : BURST_W'(1);
        w_mask_data = '0;
        w_en        = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            if (i < int'(w_sb)) begin
                w_mask_data[i*8 +: 8] = r_data[i*8 +: 8];
                w_en[i]               = 1'b1;
            end
        end
        // A sub-beat access always fits inside beat 0, so the lane shift
        // never pushes data across a beat boundary.
        w_wdata   = w_mask_data << {w_off, 3'b000};
        w_byte_en = w_en << w_off;
    end

    // Current-beat views; constant-index loops avoid variable part-selects.
    always_comb begin
        w_assembled = r_beats;
        w_beat_data = '0;
        w_beat_en   = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (BURST_W'(b) == r_beat) begin
                w_assembled[b*MEM_W +: MEM_W] = ctl_rd_data;
                w_beat_data = r_data[b*MEM_W +: MEM_W];
                w_beat_en   = r_byte_en[b*LANE_B +: LANE_B];
            end
        end
    end

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .i_beats  (w_assembled),
        .i_off    (r_off),
        .i_size   (r_size),
        .o_result (w_ext)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_CHECK;
            ST_CHECK: w_next = w_err ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (ctl_idle) w_next = r_is_wr ? ST_WDATA : ST_RDATA;
            ST_RDATA: if (ctl_rd_data_valid && w_last) w_next = ST_DONE;
            ST_WDATA: if (ctl_wr_ack && w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_data    <= '0;
            r_is_wr   <= 1'b0;
            r_err     <= 1'b0;
            r_nbeats  <= '0;
            r_beat    <= '0;
            r_off     <= '0;
            r_byte_en <= '0;
            r_beats   <= '0;
            r_outdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= mem_addr;
                        r_size  <= mem_size;
                        r_data  <= indata;
                        r_is_wr <= wr_req;   // store wins a tie
                        r_err   <= 1'b0;
                        r_beat  <= '0;
                        r_beats <= '0;
                    end
                end
                ST_CHECK: begin
                    r_err     <= w_err;
                    r_nbeats  <= w_nbeats;
                    r_off     <= w_off;
                    r_byte_en <= w_byte_en;
                    r_data    <= w_wdata;
                    if (w_err && !r_is_wr) begin
                        r_outdata <= '0;
                    end
                end
                ST_RDATA: begin
                    if (ctl_rd_data_valid) begin
                        r_beats <= w_assembled;
                        if (w_last) begin
                            r_beat    <= '0;
                            r_outdata <= w_ext;
                        end else begin
                            r_beat <= r_beat + BURST_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (ctl_wr_ack) begin
                        r_beat <= w_last ? '0 : r_beat + BURST_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state so an asynchronous reset clears them
    // in the same cycle.
    assign w_busy      = (r_state == ST_ISSUE) || (r_state == ST_RDATA) || (r_state == ST_WDATA);
    assign ctl_addr    = w_busy ? (r_addr >> LANE_SH) + ADDR_W'(r_beat) : '0;
    assign ctl_burst   = w_busy ? r_nbeats : '0;
    assign ctl_rd_req  = (r_state == ST_ISSUE) && ctl_idle && !r_is_wr;
    assign ctl_wr_req  = (r_state == ST_ISSUE) && ctl_idle && r_is_wr;
    assign ctl_wr_data = (r_state == ST_WDATA) ? w_beat_data : '0;
    assign ctl_dqm     = (r_state == ST_WDATA) ? ~w_beat_en : '1;
    assign rd_valid    = (r_state == ST_DONE) && !r_is_wr;
    assign wr_valid    = (r_state == ST_DONE) && r_is_wr;
    assign acc_err     = (r_state == ST_DONE) && r_err;
    assign outdata     = r_outdata;
    assign o_dbg_state = r_state;

endmodule
